// File: rtl/ddr3_app_pkg.sv
// Command codes and state encodings shared by the DDR3 app-interface responder.
package ddr3_app_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic {INIT, RUN} calib_state_t;
   typedef enum logic {EXEC, WAIT_WDATA} exec_state_t;

endpackage

// File: rtl/ddr3_resp_fifo.sv
// Synchronous fall-through FIFO: rdata shows the head entry whenever empty is low.
module ddr3_resp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/ddr3_app_responder.sv
// RAM-backed responder for the MIG-style DDR3 app interface with fixed read latency.
// Define DDR3_RESP_STALL_EN to add LFSR-driven random backpressure on app_rdy/app_wdf_rdy.
module ddr3_app_responder
   import ddr3_app_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 29,
   parameter int unsigned DATA_WIDTH     = 128,
   parameter int unsigned MEM_DEPTH_LOG2 = 10,
   parameter int unsigned ADDR_LSB       = 3,
   parameter int unsigned READ_LATENCY   = 4,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned INIT_CYCLES    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   app_addr,
   input  logic [2:0]              app_cmd,
   input  logic                    app_en,
   output logic                    app_rdy,
   input  logic [DATA_WIDTH-1:0]   app_wdf_data,
   input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
   input  logic                    app_wdf_wren,
   input  logic                    app_wdf_end,
   output logic                    app_wdf_rdy,
   output logic [DATA_WIDTH-1:0]   app_rd_data,
   output logic                    app_rd_data_valid,
   output logic                    init_calib_complete,
   output logic                    proto_err
);

   localparam int unsigned MASK_W = DATA_WIDTH / 8;
   localparam int unsigned CMD_W  = 3 + MEM_DEPTH_LOG2;
   localparam int unsigned WDF_W  = DATA_WIDTH + MASK_W;
   localparam int unsigned CNT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   calib_state_t calib_q, calib_d;
   exec_state_t  exec_q, exec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic run, stall_cmd, stall_wdf;

   logic cmd_push, cmd_pop, cmd_full, cmd_empty;
   logic wdf_push, wdf_pop, wdf_full, wdf_empty;
   logic [CMD_W-1:0] cmd_rdata;
   logic [WDF_W-1:0] wdf_rdata;
   logic [2:0]                head_cmd;
   logic [MEM_DEPTH_LOG2-1:0] head_idx;
   logic [DATA_WIDTH-1:0]     head_data;
   logic [MASK_W-1:0]         head_mask;
   logic rd_exec, wr_exec, proto_err_q;

   logic [DATA_WIDTH-1:0]   mem [2**MEM_DEPTH_LOG2];
   logic [READ_LATENCY-1:0] vld_q;
   logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

   logic unused_addr;
   assign unused_addr = ^app_addr;

   // Calibration
   always_ff @(posedge clk) begin
      if (rst) begin
         calib_q <= INIT;
         cnt_q   <= '0;
      end else begin
         calib_q <= calib_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      calib_d = calib_q;
      cnt_d   = cnt_q;
      if (calib_q == INIT) begin
         if (INIT_CYCLES == 0 || cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
            calib_d = RUN;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign run                 = (calib_q == RUN);
   assign init_calib_complete = run;

`ifdef DDR3_RESP_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign stall_cmd = lfsr_q[0];
   assign stall_wdf = lfsr_q[1];
`else
   assign stall_cmd = 1'b0;
   assign stall_wdf = 1'b0;
`endif

   // Ready depends only on registered state, never on app_en/app_wdf_wren.
   assign app_rdy     = run && !cmd_full && !stall_cmd;
   assign app_wdf_rdy = run && !wdf_full && !stall_wdf;
   assign cmd_push    = app_en && app_rdy;
   assign wdf_push    = app_wdf_wren && app_wdf_rdy;

   ddr3_resp_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_push),
      .wdata ({app_cmd, app_addr[ADDR_LSB +: MEM_DEPTH_LOG2]}),
      .pop   (cmd_pop),
      .rdata (cmd_rdata),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   ddr3_resp_fifo #(
      .WIDTH (WDF_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wdf_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wdf_push),
      .wdata ({app_wdf_data, app_wdf_mask}),
      .pop   (wdf_pop),
      .rdata (wdf_rdata),
      .full  (wdf_full),
      .empty (wdf_empty)
   );

   assign head_cmd  = cmd_rdata[CMD_W-1 -: 3];
   assign head_idx  = cmd_rdata[MEM_DEPTH_LOG2-1:0];
   assign head_data = wdf_rdata[WDF_W-1 -: DATA_WIDTH];
   assign head_mask = wdf_rdata[MASK_W-1:0];

   // Executor
   always_ff @(posedge clk) begin
      if (rst) begin
         exec_q <= EXEC;
      end else begin
         exec_q <= exec_d;
      end
   end

   always_comb begin
      exec_d  = exec_q;
      cmd_pop = 1'b0;
      wdf_pop = 1'b0;
      rd_exec = 1'b0;
      wr_exec = 1'b0;
      unique case (exec_q)
         EXEC: begin
            if (!cmd_empty) begin
               if (head_cmd == CMD_READ) begin
                  cmd_pop = 1'b1;
                  rd_exec = 1'b1;
               end else if (head_cmd == CMD_WRITE) begin
                  if (!wdf_empty) begin
                     cmd_pop = 1'b1;
                     wdf_pop = 1'b1;
                     wr_exec = 1'b1;
                  end else begin
                     exec_d = WAIT_WDATA;
                  end
               end else begin
                  // Illegal opcode: discard without effect.
                  cmd_pop = 1'b1;
               end
            end
         end
         WAIT_WDATA: begin
            if (!wdf_empty) begin
               cmd_pop = 1'b1;
               wdf_pop = 1'b1;
               wr_exec = 1'b1;
               exec_d  = EXEC;
            end
         end
         default: exec_d = EXEC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_exec && !rst) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (!head_mask[b]) begin
               mem[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
            end
         end
      end
   end

   // Each data stage loads only behind a valid, so the last stage holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= rd_exec;
         if (rd_exec) begin
            dat_q[0] <= mem[head_idx];
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i] <= dat_q[i-1];
            end
         end
      end
   end

   assign app_rd_data_valid = vld_q[READ_LATENCY-1];
   assign app_rd_data       = dat_q[READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err_q <= 1'b0;
      end else if ((cmd_push && app_cmd != CMD_WRITE && app_cmd != CMD_READ) ||
                   (wdf_push && !app_wdf_end)) begin
         proto_err_q <= 1'b1;
      end
   end

   assign proto_err = proto_err_q;

endmodule
